// File: rtl/ram3_dbg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ram3_dbg                                                       |
// | Brief   : Three-read / one-write synchronous scratchpad RAM serving HLS  |
// |           kernel memory ports, plus a side-band debug write/read port    |
// |           for preloading operands and reading back results.              |
// | Options : RAM_BYPASS_EN - forward same-edge write data to kernel reads.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ram3_dbg #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [WIDTH-1:0]      rdata0,
  output logic [WIDTH-1:0]      rdata1,
  output logic [WIDTH-1:0]      rdata2,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] debug_write_addr,
  input  logic [WIDTH-1:0]      debug_write_data,
  input  logic                  debug_write_en,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [WIDTH-1:0]      debug_data
);

  // DEPTH widened by one bit so an all-ones address compares correctly.
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] w_raddr [3];
  logic                  w_kwr;
  logic                  w_dwr;

  // Addresses at or beyond DEPTH read as zero on every port.
  function automatic logic [WIDTH-1:0] f_rd(input logic [ADDR_WIDTH-1:0] a);
    if ({1'b0, a} < c_DEPTH) return r_mem[a];
    return '0;
  endfunction

  // Kernel writes are lost while reset is high; debug writes never are.
  assign w_kwr = wen & ~rst & ({1'b0, waddr} < c_DEPTH);
  assign w_dwr = debug_write_en & ({1'b0, debug_write_addr} < c_DEPTH);

  // Storage update: debug write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (w_kwr) r_mem[waddr] <= wdata;
    if (w_dwr) r_mem[debug_write_addr] <= debug_write_data;
  end

  assign debug_data = f_rd(debug_addr);

  assign w_raddr[0] = raddr0;
  assign w_raddr[1] = raddr1;
  assign w_raddr[2] = raddr2;

  for (genvar i = 0; i < 3; i++) begin : g_rd
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_q;

`ifdef RAM_BYPASS_EN
    // Read data with forwarding of writes committing at the same edge.
    always_comb begin
      w_next = f_rd(w_raddr[i]);
      if (w_kwr && (waddr == w_raddr[i])) w_next = wdata;
      if (w_dwr && (debug_write_addr == w_raddr[i])) w_next = debug_write_data;
    end
`else
    // Read-before-write: the array value ahead of this edge's writes.
    always_comb begin
      w_next = f_rd(w_raddr[i]);
    end
`endif

    // Registered read port, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '0;
      else     r_q <= w_next;
    end
  end : g_rd

  assign rdata0 = g_rd[0].r_q;
  assign rdata1 = g_rd[1].r_q;
  assign rdata2 = g_rd[2].r_q;

endmodule
`default_nettype wire

// File: tb/tb_ram3_dbg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ram3_dbg                                                    |
// | Brief   : Directed, table-driven self-checking bench for ram3_dbg.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram3_dbg;

`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr0, raddr1, raddr2, waddr, debug_write_addr, debug_addr;
  logic [31:0] rdata0, rdata1, rdata2, wdata, debug_write_data, debug_data;
  logic        wen, debug_write_en;

  int n_cmp = 0;
  int n_bad = 0;

  ram3_dbg #(.WIDTH(32), .DEPTH(20), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2),
    .waddr(waddr), .wdata(wdata), .wen(wen),
    .debug_write_addr(debug_write_addr), .debug_write_data(debug_write_data),
    .debug_write_en(debug_write_en),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  ra0, ra1, ra2;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        dwe;
    logic [4:0]  dwa;
    logic [31:0] dwd;
    logic [4:0]  da;
    logic [31:0] e0, e1, e2, ed;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic r, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic dwe, logic [4:0] dwa, logic [31:0] dwd,
                              logic [4:0] da, logic [31:0] e0, logic [31:0] e1,
                              logic [31:0] e2, logic [31:0] ed);
    vec_t v;
    v.rst = r; v.ra0 = a0; v.ra1 = a1; v.ra2 = a2;
    v.wen = we; v.wa = wa; v.wd = wd;
    v.dwe = dwe; v.dwa = dwa; v.dwd = dwd;
    v.da = da; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //                   rst ra0 ra1 ra2 wen wa  wd  dwe dwa dwd  da  e0  e1  e2  ed
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 6);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0, 0, 2);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 7, 4, 0, 0, 0, 7);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1, 2, 1, 5, 55, 0, 0, 0, 5, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 6, 1, 2, 1);
    vecs[7]  = mk(0, 2, 1, 0, 1, 12, 71, 0, 0, 0, 12, 2, 1, 6, 71);
    vecs[8]  = mk(0, 12, 12, 12, 1, 3, 5, 1, 3, 9, 3, 71, 71, 71, 9);
    vecs[9]  = mk(0, 3, 3, 3, 1, 6, 66, 1, 7, 77, 6, 9, 9, 9, 66);
    vecs[10] = mk(0, 6, 7, 3, 0, 0, 0, 0, 0, 0, 7, 66, 77, 9, 77);
    vecs[11] = mk(0, 4, 4, 0, 1, 4, 83, 0, 0, 0, 4,
                  BYP ? 32'd83 : 32'd7, BYP ? 32'd83 : 32'd7, 6, 83);
    vecs[12] = mk(0, 4, 1, 1, 0, 0, 0, 1, 1, 11, 1,
                  83, BYP ? 32'd11 : 32'd1, BYP ? 32'd11 : 32'd1, 11);
    vecs[13] = mk(0, 4, 1, 2, 1, 2, 20, 1, 2, 22, 2,
                  83, 11, BYP ? 32'd22 : 32'd2, 22);
    vecs[14] = mk(0, 4, 25, 2, 1, 25, 99, 0, 0, 0, 25, 83, 0, 22, 0);
    vecs[15] = mk(0, 4, 30, 12, 0, 0, 0, 1, 19, 123, 19, 83, 0, 71, 123);
    vecs[16] = mk(0, 19, 20, 25, 0, 0, 0, 1, 20, 5, 20, 123, 0, 0, 0);

    rst = 1'b1;
    raddr0 = '0; raddr1 = '0; raddr2 = '0;
    waddr = '0; wdata = '0; wen = 1'b0;
    debug_write_addr = '0; debug_write_data = '0; debug_write_en = 1'b0;
    debug_addr = '0;

    #1;
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_rdata2", rdata2, 32'd0);

    // Table: drive while clk is low, check 1 time unit after the rising edge.
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      raddr0 = vecs[i].ra0; raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      wen = vecs[i].wen; waddr = vecs[i].wa; wdata = vecs[i].wd;
      debug_write_en = vecs[i].dwe; debug_write_addr = vecs[i].dwa;
      debug_write_data = vecs[i].dwd; debug_addr = vecs[i].da;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].e0);
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e1);
      chk($sformatf("v%0d_rdata2", i), rdata2, vecs[i].e2);
      chk($sformatf("v%0d_debug", i), debug_data, vecs[i].ed);
      @(negedge clk);
    end

    // Hold between edges, then asynchronous reset mid-run.
    wen = 1'b0; debug_write_en = 1'b0;
    raddr0 = 5'd4; raddr1 = 5'd0; raddr2 = 5'd0;
    @(posedge clk); #1;
    chk("pre_rst_rdata0", rdata0, 32'd83);
    @(negedge clk);
    raddr0 = 5'd0;
    #1;
    chk("hold_before_edge", rdata0, 32'd83);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rdata0", rdata0, 32'd0);
    chk("async_rst_rdata1", rdata1, 32'd0);
    chk("async_rst_rdata2", rdata2, 32'd0);
    wen = 1'b1; waddr = 5'd12; wdata = 32'd0; debug_addr = 5'd12;
    @(posedge clk); #1;
    chk("wen_in_rst_dropped", debug_data, 32'd71);
    chk("rst_hold_rdata0", rdata0, 32'd0);
    @(negedge clk);
    wen = 1'b0; rst = 1'b0; raddr0 = 5'd12;
    @(posedge clk); #1;
    chk("post_rst_read12", rdata0, 32'd71);

    // Final contents sweep: nothing clobbered by out-of-range or dropped writes.
    begin
      logic [4:0]  sa [10];
      logic [31:0] sv [10];
      sa = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 19};
      sv = '{6, 11, 22, 9, 83, 0, 66, 77, 71, 123};
      for (int k = 0; k < 10; k++) begin
        debug_addr = sa[k];
        #1;
        chk($sformatf("sweep_mem%0d", sa[k]), debug_data, sv[k]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
